param_fifo: RTL and testbench

PARAM_FIFO -- requirements
Module: param_fifo

---
 rtl/param_fifo.sv | 123 ++++++++++++
 tb/tb_param_fifo.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/param_fifo.sv
// Parameterized synchronous FIFO with sticky over/underflow flags,
// almost-full/almost-empty thresholds and selectable standard or
// first-word-fall-through read mode.
module param_fifo #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 4,
   parameter int AF_LEVEL = 12,
   parameter int AE_LEVEL = 4,
   parameter int FWFT     = 0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              en,
   input  logic              clr,
   input  logic              write,
   input  logic [DATA_W-1:0] data_in,
   input  logic              read,
   output logic [DATA_W-1:0] data_out,
   output logic              valid,
   output logic              empty,
   output logic              full,
   output logic              almost_empty,
   output logic              almost_full,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              underflow
);

   localparam int              DEPTH   = 1 << ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LEVEL);
   localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_LEVEL);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic [ADDR_W:0]   cnt;
   logic              wr_req, rd_req, wr_ok, rd_ok;

   // Requests only count when enabled and not being flushed. A read frees a
   // slot in the same cycle, so a full FIFO still takes a paired write; an
   // empty FIFO never bypasses a write straight to the reader.
   assign wr_req = en & write & ~clr;
   assign rd_req = en & read  & ~clr;
   assign rd_ok  = rd_req & ~empty;
   assign wr_ok  = wr_req & (~full | rd_ok);

   // Status is derived purely from the registered count.
   assign count        = cnt;
   assign empty        = (cnt == '0);
   assign full         = (cnt == DEPTH_C);
   assign almost_empty = (cnt <= AE_C);
   assign almost_full  = (cnt >= AF_C);

   // Pointers and occupancy; clr wins over any request.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
         if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_ok, rd_ok})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   // Sticky error flags: set on a rejected enabled request, cleared by clr.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (clr) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_req && !wr_ok) overflow  <= 1'b1;
         if (rd_req && !rd_ok) underflow <= 1'b1;
      end
   end

   // Storage array; deliberately never reset so it maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= data_in;
   end

   generate
      if (FWFT != 0) begin : g_fwft
         // Head word is visible combinationally; gated to zero while empty so
         // reset and flush present a clean bus instead of stale RAM.
         assign valid    = ~empty;
         assign data_out = valid ? mem[rd_ptr] : '0;
      end else begin : g_std
         logic [DATA_W-1:0] dout_q;
         logic              vld_q;

         // Registered pop: data lands the cycle after an accepted read and
         // holds afterwards; valid is a one-cycle strobe.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               dout_q <= '0;
               vld_q  <= 1'b0;
            end else if (clr) begin
               vld_q  <= 1'b0;
            end else if (en) begin
               vld_q  <= rd_ok;
               if (rd_ok) dout_q <= mem[rd_ptr];
            end
         end

         assign valid    = vld_q;
         assign data_out = dout_q;
      end
   endgenerate

endmodule

// File: tb/tb_param_fifo.sv
// Bench for param_fifo: one standard-mode and one FWFT instance share the
// same stimulus and are compared every cycle against a queue-based model.
module tb_param_fifo;

   logic       clk, reset_n, en, clr, write, read;
   logic [7:0] data_in;

   logic [7:0] s_dout, f_dout;
   logic       s_vld, s_emp, s_full, s_ae, s_af, s_ovf, s_unf;
   logic       f_vld, f_emp, f_full, f_ae, f_af, f_ovf, f_unf;
   logic [4:0] s_cnt, f_cnt;

   int total = 0;
   int bad   = 0;

   // reference model state
   logic [7:0] q[$];
   logic       m_ovf, m_unf, m_vld;
   logic [7:0] m_dout;

   param_fifo #(.FWFT(0)) u_std (
      .clk(clk), .reset_n(reset_n), .en(en), .clr(clr), .write(write),
      .data_in(data_in), .read(read), .data_out(s_dout), .valid(s_vld),
      .empty(s_emp), .full(s_full), .almost_empty(s_ae), .almost_full(s_af),
      .count(s_cnt), .overflow(s_ovf), .underflow(s_unf));

   param_fifo #(.FWFT(1)) u_fw (
      .clk(clk), .reset_n(reset_n), .en(en), .clr(clr), .write(write),
      .data_in(data_in), .read(read), .data_out(f_dout), .valid(f_vld),
      .empty(f_emp), .full(f_full), .almost_empty(f_ae), .almost_full(f_af),
      .count(f_cnt), .overflow(f_ovf), .underflow(f_unf));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      int n;
      logic [7:0] head;
      n    = q.size();
      head = (n > 0) ? q[0] : 8'h00;
      chk({tag, ".s_count"}, 32'(s_cnt), 32'(n));
      chk({tag, ".s_empty"}, 32'(s_emp), 32'(n == 0));
      chk({tag, ".s_full"},  32'(s_full), 32'(n == 16));
      chk({tag, ".s_ae"},    32'(s_ae), 32'(n <= 4));
      chk({tag, ".s_af"},    32'(s_af), 32'(n >= 12));
      chk({tag, ".s_ovf"},   32'(s_ovf), 32'(m_ovf));
      chk({tag, ".s_unf"},   32'(s_unf), 32'(m_unf));
      chk({tag, ".s_valid"}, 32'(s_vld), 32'(m_vld));
      chk({tag, ".s_dout"},  32'(s_dout), 32'(m_dout));
      chk({tag, ".f_count"}, 32'(f_cnt), 32'(n));
      chk({tag, ".f_empty"}, 32'(f_emp), 32'(n == 0));
      chk({tag, ".f_full"},  32'(f_full), 32'(n == 16));
      chk({tag, ".f_ae"},    32'(f_ae), 32'(n <= 4));
      chk({tag, ".f_af"},    32'(f_af), 32'(n >= 12));
      chk({tag, ".f_ovf"},   32'(f_ovf), 32'(m_ovf));
      chk({tag, ".f_unf"},   32'(f_unf), 32'(m_unf));
      chk({tag, ".f_valid"}, 32'(f_vld), 32'(n > 0));
      chk({tag, ".f_dout"},  32'(f_dout), 32'(head));
   endtask

   task automatic model_reset();
      q.delete();
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
      m_vld  = 1'b0;
      m_dout = 8'h00;
   endtask

   // One clock: drive inputs, advance the model, then compare after the edge.
   task automatic step(input string tag, input logic e, input logic c,
                       input logic w, input logic r, input logic [7:0] d);
      logic ra, wa;
      en = e; clr = c; write = w; read = r; data_in = d;
      if (c) begin
         q.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
         m_vld = 1'b0;
      end else if (e) begin
         ra = r && (q.size() > 0);
         wa = w && ((q.size() < 16) || ra);
         if (r && !ra) m_unf = 1'b1;
         if (w && !wa) m_ovf = 1'b1;
         m_vld = ra;
         if (ra) m_dout = q.pop_front();
         if (wa) q.push_back(d);
      end
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic async_reset(input string tag);
      #2 reset_n = 1'b0;
      model_reset();
      #1 check_all(tag);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n = 1'b0; en = 1'b0; clr = 1'b0; write = 1'b0; read = 1'b0; data_in = '0;
      model_reset();
      #3 check_all("reset");
      #9 reset_n = 1'b1;

      // fill with 0x03..0x12, then drain in order
      for (int i = 0; i < 16; i++) step("fill", 1, 0, 1, 0, 8'(8'h03 + i));
      for (int i = 0; i < 16; i++) step("drain", 1, 0, 0, 1, 8'h00);
      step("idle", 1, 0, 0, 0, 8'h00);

      // overflow on full, then flush
      for (int i = 0; i < 16; i++) step("fill2", 1, 0, 1, 0, 8'($urandom));
      step("ovf", 1, 0, 1, 0, 8'hEE);
      step("clr", 1, 1, 0, 0, 8'h00);

      // read+write on empty: write only, underflow set
      step("rw_empty", 1, 0, 1, 1, 8'h55);
      step("rd55", 1, 0, 0, 1, 8'h00);
      step("clr2", 0, 1, 0, 0, 8'h00);

      // full with simultaneous read+write across pointer wrap
      for (int i = 0; i < 16; i++) step("fill3", 1, 0, 1, 0, 8'($urandom));
      for (int i = 0; i < 20; i++) step("rw_full", 1, 0, 1, 1, 8'($urandom));
      step("clr3", 1, 1, 0, 0, 8'h00);

      // fall-through latency into empty, no read
      step("fwft_a1", 1, 0, 1, 0, 8'hA1);
      step("fwft_hold", 1, 0, 0, 0, 8'h00);

      // disabled requests change nothing
      step("dis_w", 0, 0, 1, 0, 8'h12);
      step("dis_r", 0, 0, 0, 1, 8'h00);
      step("dis_rw", 0, 0, 1, 1, 8'h34);

      // random burst with an asynchronous reset in the middle
      for (int i = 0; i < 60; i++) begin
         step("rand", ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0),
              1'($urandom), 1'($urandom), 8'($urandom));
         if (i == 30) async_reset("rst_mid");
      end

      // stale words are gone after reset; first write is first read
      async_reset("rst_end");
      step("post_w0", 1, 0, 1, 0, 8'h77);
      step("post_w1", 1, 0, 1, 0, 8'h78);
      step("post_r0", 1, 0, 0, 1, 8'h00);
      step("post_r1", 1, 0, 0, 1, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
